expander_200: RTL and testbench

Pipelined 1-to-200 distributor: the inverse of the 200-way argmax comparator tree in the training comparison layer. It takes a character index `num` and a value `d`, then produces a 200-lane vector with `d` placed in lane `num` and zero in every other lane. Its main use is scattering a scalar (gradient, score or target weight) back onto the 200-character axis. It has the same 8-stage latency and the same `run`/`valid` counter protocol as the comparator, so the two pipelines stay cycle-aligned.

---
 rtl/expander_200.sv | 82 ++++++++
 tb/tb_expander_200.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/expander_200.sv
// Pipelined 1-to-200 distributor. It places d in lane num of a 200-lane vector through
// an 8-level registered binary demux tree. It follows the comparator's run/valid counter protocol.
module expander_200 #(
  parameter int CHAR_LEN = 8,
  parameter int N_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [CHAR_LEN-1:0]   num,
  input  logic [N_LEN-1:0]      d,
  output logic                  valid,
  output logic                  range_err,
  output logic [200*N_LEN-1:0]  q
);

  localparam int N_OUT = 200;
  localparam int DEPTH = 8;
  // Levels 1..7 are packed back to back. Level s starts at lane 2^s - 2.
  localparam int TREE_LANES = (1 << DEPTH) - 2;

  function automatic int base(input int s);
    return (1 << s) - 2;
  endfunction

  logic [N_LEN-1:0]    tree     [TREE_LANES];
  logic [N_LEN-1:0]    out_lane [N_OUT];
  logic [CHAR_LEN-1:0] num_pipe [1:DEPTH-1];
  logic [DEPTH:1]      err_pipe;
  logic [3:0]          count;
  logic                err_in;
  logic [N_LEN-1:0]    d_in;

  // Out-of-range indices inject zero. This keeps q clear even for index bits above the tree.
  assign err_in = (32'(num) >= N_OUT);
  assign d_in   = err_in ? '0 : d;

  // NOTE: the lane arrays are real pipeline state, not RAM, so they are cleared by rst_n like every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TREE_LANES; i++) tree[i] <= '0;
      for (int i = 0; i < N_OUT; i++) out_lane[i] <= '0;
      for (int s = 1; s < DEPTH; s++) num_pipe[s] <= '0;
      err_pipe <= '0;
    end else if (run) begin
      // NOTE: non-blocking assignments let every level read last cycle's value of the level above.
      num_pipe[1] <= num;
      for (int s = 2; s < DEPTH; s++) num_pipe[s] <= num_pipe[s-1];
      err_pipe <= {err_pipe[DEPTH-1:1], err_in};

      tree[0] <= num[DEPTH-1] ? '0 : d_in;
      tree[1] <= num[DEPTH-1] ? d_in : '0;
      for (int s = 2; s < DEPTH; s++) begin
        for (int j = 0; j < (1 << s); j++) begin
          tree[base(s)+j] <= (num_pipe[s-1][DEPTH-s] == 1'(j))
                             ? tree[base(s-1)+(j>>1)] : '0;
        end
      end
      // Only lanes 0..199 of the last level are kept.
      for (int j = 0; j < N_OUT; j++) begin
        out_lane[j] <= (num_pipe[DEPTH-1][0] == 1'(j))
                       ? tree[base(DEPTH-1)+(j>>1)] : '0;
      end
    end
  end

  // The counter matches the comparator: it counts up to 8, holds there, and clears whenever run drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (!run)   count <= '0;
    else if (!valid) count <= count + 4'd1;
  end

  assign valid     = (count == 4'd8);
  assign range_err = err_pipe[DEPTH];

  always_comb begin
    q = '0;
    for (int i = 0; i < N_OUT; i++) q[i*N_LEN +: N_LEN] = out_lane[i];
  end

endmodule

// File: tb/tb_expander_200.sv
// Directed self-checking bench for expander_200. Each step uses hand-computed lane,
// valid and range_err expectations.
module tb_expander_200;

  localparam int N_LEN = 16;
  localparam int N_OUT = 200;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   run = 1'b0;
  logic [7:0]             num = '0;
  logic [N_LEN-1:0]       d = '0;
  logic                   valid;
  logic                   range_err;
  logic [N_OUT*N_LEN-1:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  expander_200 #(.CHAR_LEN(8), .N_LEN(N_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .num(num), .d(d),
    .valid(valid), .range_err(range_err), .q(q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all of q against a vector that holds val in lane idx, or all zeros when idx >= 200.
  task automatic check_q(input string tag, input int idx, input logic [N_LEN-1:0] val);
    logic [N_OUT*N_LEN-1:0] e;
    int first;
    e = '0;
    if (idx < N_OUT) e[idx*N_LEN +: N_LEN] = val;
    n_cmp++;
    assert (q === e) else begin
      n_bad++;
      first = 0;
      for (int i = N_OUT - 1; i >= 0; i--)
        if (q[i*N_LEN +: N_LEN] !== e[i*N_LEN +: N_LEN]) first = i;
      $error("FAIL %s: lane %0d observed %h expected %h", tag, first,
             q[first*N_LEN +: N_LEN], e[first*N_LEN +: N_LEN]);
    end
  endtask

  // Starting from count=0 with run high, valid must stay low for 7 edges and rise on the 8th.
  task automatic expect_fill(input string tag);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("%s_valid_lo_e%0d", tag, i), 32'(valid), 32'd0);
    end
    tick();
    check({tag, "_valid_hi"}, 32'(valid), 32'd1);
  endtask

  task automatic apply_and_check(input string tag, input logic [7:0] n,
                                 input logic [N_LEN-1:0] v, input logic err);
    num = n;
    d   = v;
    repeat (8) tick();
    check_q({tag, "_q"}, err ? N_OUT : int'(n), v);
    check({tag, "_err"}, 32'(range_err), 32'(err));
    check({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check_q("reset_q", N_OUT, '0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_err", 32'(range_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // First pass: lane 0 = 1234 after edge 8
    run = 1'b1;
    num = 8'd0;
    d   = 16'h1234;
    expect_fill("first");
    check_q("first_q", 0, 16'h1234);
    check("first_err", 32'(range_err), 32'd0);

    // Bit-boundary and range edges while streaming
    apply_and_check("n199", 8'd199, 16'hFFFF, 1'b0);
    apply_and_check("n100", 8'd100, 16'hFFFF, 1'b0);
    apply_and_check("n127", 8'd127, 16'hFFFF, 1'b0);
    apply_and_check("n128", 8'd128, 16'h8001, 1'b0);
    apply_and_check("n200", 8'd200, 16'hAAAA, 1'b1);
    apply_and_check("n255", 8'd255, 16'hAAAA, 1'b1);
    apply_and_check("d_zero", 8'd42, 16'h0000, 1'b0);

    // Stream 3,4,5 on consecutive cycles
    num = 8'd3; d = 16'd1; tick();
    num = 8'd4; d = 16'd2; tick();
    num = 8'd5; d = 16'd3; tick();
    repeat (5) tick();
    check_q("stream_c8", 3, 16'd1);
    check("stream_c8_valid", 32'(valid), 32'd1);
    tick();
    check_q("stream_c9", 4, 16'd2);
    check("stream_c9_valid", 32'(valid), 32'd1);
    tick();
    check_q("stream_c10", 5, 16'd3);
    check("stream_c10_valid", 32'(valid), 32'd1);

    // Dropping run clears valid but holds the data
    run = 1'b0;
    num = 8'd10;
    d   = 16'd7;
    tick();
    check("drop_valid", 32'(valid), 32'd0);
    check_q("drop_hold_q", 5, 16'd3);

    // Run high 4, low 2, high again: levels 1..4 must keep lane 10 through the gap
    run = 1'b1;
    repeat (4) tick();
    check("gap_pre_valid", 32'(valid), 32'd0);
    run = 1'b0;
    repeat (2) tick();
    check("gap_low_valid", 32'(valid), 32'd0);
    check_q("gap_low_q", 5, 16'd3);
    run = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("gap_valid_lo_e%0d", i), 32'(valid), 32'd0);
      if (i == 4) check_q("gap_retained_q", 10, 16'd7);
    end
    tick();
    check("gap_valid_hi", 32'(valid), 32'd1);
    check_q("gap_final_q", 10, 16'd7);

    // Asynchronous reset mid-stream, away from any clock edge
    num = 8'd77;
    d   = 16'hBEEF;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_q("async_rst_q", N_OUT, '0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_err", 32'(range_err), 32'd0);
    // Reset dominates a clock edge with run low
    run = 1'b0;
    tick();
    check("rst_run_lo_valid", 32'(valid), 32'd0);
    check_q("rst_run_lo_q", N_OUT, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    #1;
    expect_fill("after_rst");
    check_q("after_rst_q", 77, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
